// File: rtl/alu_unit.sv
// alu_unit: two-stage pipelined signed ALU (add, sub, mul, div).
// Stage 1 registers the operands and function code. Stage 2 computes the
// 2*WIDTH-bit result and overflow flag from stage 1 and registers them.
// Multiply is a shift-add partial-product array. Divide is an unrolled
// restoring divider on magnitudes followed by sign correction.

module alu_unit #(
    parameter int WIDTH = 6
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         func,
    output logic [2*WIDTH-1:0] out,
    output logic               overflow
);

    localparam int W2 = 2 * WIDTH;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        FUNC_ADD = 2'b00,
        FUNC_SUB = 2'b01,
        FUNC_MUL = 2'b10,
        FUNC_DIV = 2'b11
    } func_e;

    // ------------------------------------------------------------------
    // Stage 1: operand / function registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    func_e            func_q, func_d;

    // Stage 1 next-state: capture the live inputs every cycle.
    always_comb begin
        a_d    = a;
        b_d    = b;
        func_d = func_e'(func);
    end

    // Stage 1 registers; reset clears them so the flushed slot reads as 0+0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a_q    <= ZERO_W;
            b_q    <= ZERO_W;
            func_q <= FUNC_ADD;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            func_q <= func_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 datapath: add / sub at WIDTH+1 bits
    // ------------------------------------------------------------------
    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;

    // Sign-extend by one bit so the true sum/difference is always exact.
    always_comb begin
        sum_s  = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
        diff_s = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
    end

    // ------------------------------------------------------------------
    // Stage 2 datapath: shift-add signed multiplier
    // ------------------------------------------------------------------
    // The multiplicand is sign-extended to 2*WIDTH; the multiplier's low
    // WIDTH-1 bits carry positive weight and its sign bit carries weight
    // -2^(WIDTH-1), so that last partial product is subtracted.
    logic [W2-1:0]    mcand_s;
    logic [WIDTH-1:0] mplier_s;
    logic [W2-1:0]    prod_s;

    // Accumulate one partial product per multiplier bit.
    always_comb begin
        mcand_s  = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        mplier_s = b_q;
        prod_s   = {W2{1'b0}};
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (mplier_s[0]) begin
                prod_s = prod_s + mcand_s;
            end else begin
                prod_s = prod_s;
            end
            mcand_s  = mcand_s << 1'b1;
            mplier_s = mplier_s >> 1'b1;
        end
        if (mplier_s[0]) begin
            prod_s = prod_s - mcand_s;
        end else begin
            prod_s = prod_s;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 datapath: restoring divider on magnitudes
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH:0]   part_s;
    logic [WIDTH-1:0] dvd_s;
    logic [WIDTH-1:0] mag_r_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        if (a_q[WIDTH-1]) begin
            mag_a_s = ~a_q + ONE_W;
        end else begin
            mag_a_s = a_q;
        end
        if (b_q[WIDTH-1]) begin
            mag_b_s = ~b_q + ONE_W;
        end else begin
            mag_b_s = b_q;
        end
    end

    // Unrolled restoring division: dividend bits shift out the top of dvd_s
    // into the partial remainder, quotient bits shift in at the bottom.
    always_comb begin
        dvd_s  = mag_a_s;
        part_s = {(WIDTH+1){1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            part_s = {part_s[WIDTH-1:0], dvd_s[WIDTH-1]};
            if (part_s >= {1'b0, mag_b_s}) begin
                part_s = part_s - {1'b0, mag_b_s};
                dvd_s  = {dvd_s[WIDTH-2:0], 1'b1};
            end else begin
                dvd_s  = {dvd_s[WIDTH-2:0], 1'b0};
            end
        end
        mag_r_s = part_s[WIDTH-1:0];
    end

    // Sign correction: quotient negative when signs differ, remainder follows a.
    // MIN / -1 naturally wraps back to MIN here.
    always_comb begin
        if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) begin
            quo_s = ~dvd_s + ONE_W;
        end else begin
            quo_s = dvd_s;
        end
        if (a_q[WIDTH-1]) begin
            rem_s = ~mag_r_s + ONE_W;
        end else begin
            rem_s = mag_r_s;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: result select and output registers
    // ------------------------------------------------------------------
    logic [W2-1:0] out_q, out_d;
    logic          ovf_q, ovf_d;

    // Pick the result for the function registered alongside these operands.
    always_comb begin
        out_d = {W2{1'b0}};
        ovf_d = 1'b0;
        case (func_q)
            FUNC_ADD: begin
                out_d = {{(WIDTH-1){sum_s[WIDTH]}}, sum_s};
                ovf_d = sum_s[WIDTH] ^ sum_s[WIDTH-1];
            end
            FUNC_SUB: begin
                out_d = {{(WIDTH-1){diff_s[WIDTH]}}, diff_s};
                ovf_d = diff_s[WIDTH] ^ diff_s[WIDTH-1];
            end
            FUNC_MUL: begin
                out_d = prod_s;
                ovf_d = 1'b0;
            end
            FUNC_DIV: begin
                if (b_q == ZERO_W) begin
                    out_d = {ONES_W, a_q};
                    ovf_d = 1'b1;
                end else if ((a_q == MIN_W) && (b_q == ONES_W)) begin
                    out_d = {quo_s, rem_s};
                    ovf_d = 1'b1;
                end else begin
                    out_d = {quo_s, rem_s};
                    ovf_d = 1'b0;
                end
            end
            default: begin
                out_d = {W2{1'b0}};
                ovf_d = 1'b0;
            end
        endcase
    end

    // Output registers; reset discards whatever was in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_q <= {W2{1'b0}};
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign out      = out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_unit.sv
// Testbench for alu_unit (WIDTH=6): directed corner cases, exhaustive multiply,
// randomized back-to-back traffic against an integer reference model, and reset.

module tb_alu_unit;

    localparam int W = 6;

    logic            clock;
    logic            reset_n;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [1:0]      func;
    logic [2*W-1:0]  out;
    logic            overflow;

    int checks;
    int errors;

    alu_unit #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .a        (a),
        .b        (b),
        .func     (func),
        .out      (out),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: plain integer arithmetic, returns {overflow, out}.
    function automatic logic [2*W:0] model(input int sa, input int sb, input logic [1:0] f);
        int s;
        int q;
        int r;
        logic [2*W-1:0] res;
        logic [W-1:0] qv;
        logic [W-1:0] rv;
        logic ov;
        ov = 1'b0;
        case (f)
            2'b00: begin s = sa + sb; res = 12'(s); ov = (s > 31) || (s < -32); end
            2'b01: begin s = sa - sb; res = 12'(s); ov = (s > 31) || (s < -32); end
            2'b10: begin s = sa * sb; res = 12'(s); ov = 1'b0; end
            default: begin
                if (sb == 0) begin
                    q = -1; r = sa; ov = 1'b1;
                end else if (sa == -32 && sb == -1) begin
                    q = -32; r = 0; ov = 1'b1;
                end else begin
                    q = sa / sb; r = sa % sb; ov = 1'b0;
                end
                qv = 6'(q);
                rv = 6'(r);
                res = {qv, rv};
            end
        endcase
        return {ov, res};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        a = 6'd5; b = 6'd3; func = 2'b10;
        repeat (3) @(negedge clock);
        checks++;
        if (out !== 12'h000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out=%h ovf=%b required out=000 ovf=0", out, overflow);
        end
        a = 6'd0; b = 6'd0; func = 2'b00;
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_add();
        logic [W-1:0]   ta [3] = '{6'd31, 6'h20, 6'd10};
        logic [W-1:0]   tb [3] = '{6'd1, 6'h3F, 6'h3D};
        logic [2*W-1:0] to [3] = '{12'h020, 12'hFDF, 12'h007};
        logic           tv [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            a = ta[i]; b = tb[i]; func = 2'b00;
            repeat (2) @(negedge clock);
            checks++;
            if (out !== to[i] || overflow !== tv[i]) begin
                errors++;
                $display("FAIL add_%0d: out=%h ovf=%b required out=%h ovf=%b", i, out, overflow, to[i], tv[i]);
            end
        end
    endtask

    task automatic test_sub();
        logic [W-1:0]   ta [3] = '{6'h20, 6'd5, 6'd31};
        logic [W-1:0]   tb [3] = '{6'd1, 6'd9, 6'h3F};
        logic [2*W-1:0] to [3] = '{12'hFDF, 12'hFFC, 12'h020};
        logic           tv [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            a = ta[i]; b = tb[i]; func = 2'b01;
            repeat (2) @(negedge clock);
            checks++;
            if (out !== to[i] || overflow !== tv[i]) begin
                errors++;
                $display("FAIL sub_%0d: out=%h ovf=%b required out=%h ovf=%b", i, out, overflow, to[i], tv[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [W-1:0]   ta [4] = '{6'd31, 6'h39, 6'd5, 6'h20};
        logic [W-1:0]   tb [4] = '{6'd4, 6'd2, 6'd0, 6'h3F};
        logic [2*W-1:0] to [4] = '{12'h1C3, 12'hF7F, 12'hFC5, 12'h800};
        logic           tv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            a = ta[i]; b = tb[i]; func = 2'b11;
            repeat (2) @(negedge clock);
            checks++;
            if (out !== to[i] || overflow !== tv[i]) begin
                errors++;
                $display("FAIL div_%0d: out=%h ovf=%b required out=%h ovf=%b", i, out, overflow, to[i], tv[i]);
            end
        end
    endtask

    task automatic test_mul_exhaustive();
        logic [2*W:0] exp;
        int local_err;
        local_err = 0;
        for (int sa = -32; sa <= 31; sa++) begin
            for (int sb = -32; sb <= 31; sb++) begin
                @(negedge clock);
                a = 6'(sa); b = 6'(sb); func = 2'b10;
                repeat (2) @(negedge clock);
                exp = {1'b0, 12'(sa * sb)};
                checks++;
                if ({overflow, out} !== exp) begin
                    errors++;
                    local_err++;
                    if (local_err <= 10)
                        $display("FAIL mul %0d*%0d: out=%h ovf=%b required out=%h ovf=0", sa, sb, out, overflow, exp[2*W-1:0]);
                end
            end
        end
        // spot checks, with the operands held for several cycles
        @(negedge clock);
        a = 6'd31; b = 6'h20; func = 2'b10;
        repeat (5) @(negedge clock);
        checks++;
        if (out !== 12'hC20 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mul_31x-32: out=%h ovf=%b required out=C20 ovf=0", out, overflow);
        end
        @(negedge clock);
        a = 6'h20; b = 6'h20; func = 2'b10;
        repeat (5) @(negedge clock);
        checks++;
        if (out !== 12'h400 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mul_-32x-32: out=%h ovf=%b required out=400 ovf=0", out, overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W:0] exp_q [$];
        logic [2*W:0] exp;
        int n_ops;
        int sa;
        int sb;
        logic [1:0] f;
        n_ops = 300;
        for (int n = 0; n < n_ops + 2; n++) begin
            @(negedge clock);
            if (n >= 2) begin
                exp = exp_q.pop_front();
                checks++;
                if ({overflow, out} !== exp) begin
                    errors++;
                    $display("FAIL b2b_op%0d: out=%h ovf=%b required out=%h ovf=%b", n - 2, out, overflow, exp[2*W-1:0], exp[2*W]);
                end
            end
            if (n < n_ops) begin
                if (n < 4) begin
                    f = 2'(n);
                end else begin
                    f = 2'($urandom_range(0, 3));
                end
                sa = $urandom_range(0, 63) - 32;
                if ($urandom_range(0, 15) == 0) sb = 0;
                else sb = $urandom_range(0, 63) - 32;
                a = 6'(sa); b = 6'(sb); func = f;
                exp_q.push_back(model(sa, sb, f));
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clock);
        a = 6'd7; b = 6'd9; func = 2'b10;
        @(negedge clock);
        a = 6'd31; b = 6'd1; func = 2'b00;
        reset_n = 1'b0;
        @(negedge clock);
        checks++;
        if (out !== 12'h000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: out=%h ovf=%b required out=000 ovf=0", out, overflow);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (out !== 12'h000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_edge1: out=%h ovf=%b required out=000 ovf=0", out, overflow);
        end
        @(negedge clock);
        checks++;
        if (out !== 12'h020 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_edge2: out=%h ovf=%b required out=020 ovf=1", out, overflow);
        end
    endtask

    // Watchdog: the run is bounded even if something stalls the scheduler.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        a       = 6'd0;
        b       = 6'd0;
        func    = 2'b00;
        test_reset();
        test_add();
        test_sub();
        test_div();
        test_mul_exhaustive();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
